// File: rtl/main_controller_if.sv
// main_controller_if
//
// Bundles the control bus between the multicycle MIPS main controller and
// the datapath it sequences.
//
// Signals:
//   op        [5:0] instruction register bits [31:26]          (datapath -> ctrl)
//   zero            ALU zero flag of the current-cycle result   (datapath -> ctrl)
//   mem_ready       memory completes the current access         (datapath -> ctrl)
//   memread         memory read request                         (ctrl -> datapath)
//   memwrite        memory write request                        (ctrl -> datapath)
//   iord            address select, 0 = PC, 1 = ALUOut          (ctrl -> datapath)
//   irwrite         instruction register load                   (ctrl -> datapath)
//   regwrite        register file write                         (ctrl -> datapath)
//   regdst          destination select, 0 = rt, 1 = rd          (ctrl -> datapath)
//   memtoreg        writeback select, 0 = ALUOut, 1 = mem data  (ctrl -> datapath)
//   alusrca         ALU A select, 0 = PC, 1 = register A        (ctrl -> datapath)
//   alusrcb   [1:0] ALU B select: B / 4 / imm / imm << 2        (ctrl -> datapath)
//   aluop     [1:0] to alucontrol: add / sub / funct            (ctrl -> datapath)
//   pcsrc     [1:0] PC source: ALU / ALUOut / jump target       (ctrl -> datapath)
//   pcen            PC load enable                              (ctrl -> datapath)
//   illegal         unrecognised opcode seen in DECODE          (ctrl -> datapath)
//   state     [3:0] current controller state, for debug         (ctrl -> datapath)
//
// Modports:
//   master - the controller side (drives the control lines)
//   slave  - the datapath side (drives op, zero and mem_ready)

interface main_controller_if;

   logic [5:0] op;
   logic       zero;
   logic       mem_ready;

   logic       memread;
   logic       memwrite;
   logic       iord;
   logic       irwrite;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic [1:0] pcsrc;
   logic       pcen;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  op,
      input  zero,
      input  mem_ready,
      output memread,
      output memwrite,
      output iord,
      output irwrite,
      output regwrite,
      output regdst,
      output memtoreg,
      output alusrca,
      output alusrcb,
      output aluop,
      output pcsrc,
      output pcen,
      output illegal,
      output state
   );

   modport slave (
      output op,
      output zero,
      output mem_ready,
      input  memread,
      input  memwrite,
      input  iord,
      input  irwrite,
      input  regwrite,
      input  regdst,
      input  memtoreg,
      input  alusrca,
      input  alusrcb,
      input  aluop,
      input  pcsrc,
      input  pcen,
      input  illegal,
      input  state
   );

endinterface

// File: rtl/main_controller.sv
// main_controller
//
// Multicycle main control FSM for the 32-bit MIPS core. Decodes the opcode,
// sequences fetch / decode / execute / memory / writeback and drives every
// datapath select and enable. Supplies the 2-bit aluop to alucontrol and
// stalls in FETCH, MEMRD and MEMWR until the memory reports mem_ready.
//
// Ports:
//   clk    - single clock, all state updates on the rising edge
//   reset  - synchronous, active-high; also forces every control output to 0
//            while it is high
//   bus    - main_controller_if.master: op / zero / mem_ready in, all
//            control lines plus the 4-bit state code out
//
// Configuration:
//   JUMP_EN - when defined, op 000010 (j) decodes to JEX. When undefined the
//             jump opcode is treated as illegal, JEX is unreachable and
//             pcsrc never takes the value 10.

module main_controller (
   input  logic                  clk,
   input  logic                  reset,
   main_controller_if.master     bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef JUMP_EN
   localparam logic [5:0] OP_J     = 6'b000010;
`endif

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH  = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU   = 2'b00;
   localparam logic [1:0] PCSRC_OUT   = 2'b01;
`ifdef JUMP_EN
   localparam logic [1:0] PCSRC_JUMP  = 2'b10;
`endif

   state_t state_q;
   state_t state_d;

   logic       memread;
   logic       memwrite;
   logic       iord;
   logic       irwrite;
   logic       regwrite;
   logic       regdst;
   logic       memtoreg;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic [1:0] pcsrc;
   logic       pcen;
   logic       illegal;

   // State register with synchronous reset back to FETCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Any state code without a case item (12-15, and 11
   // when jumps are disabled) falls back to FETCH through the default.
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH: begin
            if (bus.mem_ready) begin
               state_d = DECODE;
            end else begin
               state_d = FETCH;
            end
         end
         DECODE: begin
            case (bus.op)
               OP_LB,
               OP_SB:    state_d = MEMADR;
               OP_RTYPE: state_d = RTYPEEX;
               OP_BEQ:   state_d = BEQEX;
               OP_ADDI:  state_d = ADDIEX;
`ifdef JUMP_EN
               OP_J:     state_d = JEX;
`endif
               default:  state_d = FETCH;
            endcase
         end
         // op is re-sampled here to pick the memory direction; the IR does
         // not change after FETCH, so this matches the DECODE decision.
         MEMADR: begin
            if (bus.op == OP_SB) begin
               state_d = MEMWR;
            end else if (bus.op == OP_LB) begin
               state_d = MEMRD;
            end else begin
               state_d = FETCH;
            end
         end
         MEMRD: begin
            if (bus.mem_ready) begin
               state_d = MEMWB;
            end else begin
               state_d = MEMRD;
            end
         end
         MEMWB:   state_d = FETCH;
         MEMWR: begin
            if (bus.mem_ready) begin
               state_d = FETCH;
            end else begin
               state_d = MEMWR;
            end
         end
         RTYPEEX: state_d = RTYPEWB;
         RTYPEWB: state_d = FETCH;
         BEQEX:   state_d = FETCH;
         ADDIEX:  state_d = ADDIWB;
         ADDIWB:  state_d = FETCH;
`ifdef JUMP_EN
         JEX:     state_d = FETCH;
`endif
         default: state_d = FETCH;
      endcase
   end

   // Output decode. Mostly Moore; the exceptions are irwrite/pcen in FETCH
   // (follow mem_ready so the IR and PC load only when the fetch completes),
   // pcen in BEQEX (follows zero) and illegal in DECODE (follows op).
   // While reset is high every control line is forced low so an aborted
   // instruction cannot write anything in the reset cycle.
   always_comb begin
      memread  = 1'b0;
      memwrite = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = SRCB_REG;
      aluop    = ALUOP_ADD;
      pcsrc    = PCSRC_ALU;
      pcen     = 1'b0;
      illegal  = 1'b0;

      case (state_q)
         FETCH: begin
            memread = 1'b1;
            alusrcb = SRCB_FOUR;
            irwrite = bus.mem_ready;
            pcen    = bus.mem_ready;
         end
         DECODE: begin
            alusrcb = SRCB_IMMSH;
            case (bus.op)
               OP_LB,
               OP_SB,
               OP_RTYPE,
               OP_BEQ,
`ifdef JUMP_EN
               OP_J,
`endif
               OP_ADDI:  illegal = 1'b0;
               default:  illegal = 1'b1;
            endcase
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         RTYPEWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PCSRC_OUT;
            pcen    = bus.zero;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
         end
         ADDIWB: begin
            regwrite = 1'b1;
         end
`ifdef JUMP_EN
         JEX: begin
            pcsrc = PCSRC_JUMP;
            pcen  = 1'b1;
         end
`endif
         default: begin
            memread = 1'b0;
         end
      endcase

      if (reset) begin
         memread  = 1'b0;
         memwrite = 1'b0;
         iord     = 1'b0;
         irwrite  = 1'b0;
         regwrite = 1'b0;
         regdst   = 1'b0;
         memtoreg = 1'b0;
         alusrca  = 1'b0;
         alusrcb  = SRCB_REG;
         aluop    = ALUOP_ADD;
         pcsrc    = PCSRC_ALU;
         pcen     = 1'b0;
         illegal  = 1'b0;
      end
   end

   assign bus.memread  = memread;
   assign bus.memwrite = memwrite;
   assign bus.iord     = iord;
   assign bus.irwrite  = irwrite;
   assign bus.regwrite = regwrite;
   assign bus.regdst   = regdst;
   assign bus.memtoreg = memtoreg;
   assign bus.alusrca  = alusrca;
   assign bus.alusrcb  = alusrcb;
   assign bus.aluop    = aluop;
   assign bus.pcsrc    = pcsrc;
   assign bus.pcen     = pcen;
   assign bus.illegal  = illegal;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_main_controller.sv
// tb_main_controller
//
// Self-checking bench for main_controller. A stimulus process walks whole
// instructions (opcode, fetch stalls, memory stalls, branch outcome) through
// the controller; for every cycle it drives the inputs and pushes the
// expected control vector, derived from the instruction's phase list and the
// per-phase control table, onto a queue. A monitor pops one entry on each
// falling edge and compares it with the outputs the DUT presents.
//
// Honours JUMP_EN the same way as the design.

module tb_main_controller;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef struct packed {
      logic       memread;
      logic       memwrite;
      logic       iord;
      logic       irwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       pcen;
      logic       illegal;
      logic [3:0] state;
   } outVec_t;

   typedef struct {
      outVec_t v;
      string   tag;
   } expEntry_t;

   logic clk = 1'b0;
   logic reset;

   expEntry_t expQ[$];
   int testsRun    = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   main_controller_if bus();

   main_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic bit opLegal(input logic [5:0] o);
      if (o == OP_RTYPE || o == OP_LB || o == OP_SB || o == OP_BEQ || o == OP_ADDI)
         return 1'b1;
`ifdef JUMP_EN
      if (o == OP_J)
         return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Control table: what each phase of an instruction must drive.
   function automatic outVec_t expectFor(input bit rst, input logic [3:0] st,
                                         input logic [5:0] o, input bit z, input bit mr);
      outVec_t e;
      e       = '0;
      e.state = st;
      if (rst)
         return e;
      case (st)
         4'd0:  begin e.memread = 1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
         4'd1:  begin e.alusrcb = 2'b11; e.illegal = !opLegal(o); end
         4'd2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
         4'd3:  begin e.memread = 1; e.iord = 1; end
         4'd4:  begin e.regwrite = 1; e.memtoreg = 1; end
         4'd5:  begin e.memwrite = 1; e.iord = 1; end
         4'd6:  begin e.alusrca = 1; e.aluop = 2'b10; end
         4'd7:  begin e.regwrite = 1; e.regdst = 1; end
         4'd8:  begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = z; end
         4'd9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
         4'd10: begin e.regwrite = 1; end
         4'd11: begin e.pcsrc = 2'b10; e.pcen = 1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   // One clock of stimulus: drive inputs, record the expectation, advance.
   task automatic stepCycle(input bit rst, input logic [5:0] o, input bit z,
                            input bit mr, input logic [3:0] st, input string tag);
      expEntry_t ent;
      reset         = rst;
      bus.op        = o;
      bus.zero      = z;
      bus.mem_ready = mr;
      ent.v   = expectFor(rst, st, o, z, mr);
      ent.tag = $sformatf("%s/st%0d", tag, st);
      expQ.push_back(ent);
      @(posedge clk);
      #1;
   endtask

   // A memory-waiting phase: stalls cycles with mem_ready low, then one ready.
   task automatic waitPhase(input logic [5:0] o, input logic [3:0] st,
                            input int stalls, input bit randomOp, input string tag);
      for (int i = 0; i < stalls; i++)
         stepCycle(0, randomOp ? 6'($urandom) : o, 1'($urandom), 1'b0, st, tag);
      stepCycle(0, randomOp ? 6'($urandom) : o, 1'($urandom), 1'b1, st, tag);
   endtask

   // Runs one complete instruction from FETCH through its last phase.
   task automatic applyStimulus(input logic [5:0] o, input bit zv, input int fStall,
                                input int mStall, input string tag);
      waitPhase(o, 4'd0, fStall, 1'b1, tag);
      stepCycle(0, o, 1'($urandom), 1'($urandom), 4'd1, tag);
      if (!opLegal(o))
         return;
      case (o)
         OP_LB: begin
            stepCycle(0, o, 1'($urandom), 1'($urandom), 4'd2, tag);
            waitPhase(o, 4'd3, mStall, 1'b0, tag);
            stepCycle(0, o, 1'($urandom), 1'($urandom), 4'd4, tag);
         end
         OP_SB: begin
            stepCycle(0, o, 1'($urandom), 1'($urandom), 4'd2, tag);
            waitPhase(o, 4'd5, mStall, 1'b0, tag);
         end
         OP_RTYPE: begin
            stepCycle(0, o, 1'($urandom), 1'($urandom), 4'd6, tag);
            stepCycle(0, o, 1'($urandom), 1'($urandom), 4'd7, tag);
         end
         OP_BEQ: begin
            stepCycle(0, o, zv, 1'($urandom), 4'd8, tag);
         end
         OP_ADDI: begin
            stepCycle(0, o, 1'($urandom), 1'($urandom), 4'd9, tag);
            stepCycle(0, o, 1'($urandom), 1'($urandom), 4'd10, tag);
         end
         OP_J: begin
            stepCycle(0, o, 1'($urandom), 1'($urandom), 4'd11, tag);
         end
         default: ;
      endcase
   endtask

   task automatic checkOutput(input expEntry_t ent);
      outVec_t act;
      act = {bus.memread, bus.memwrite, bus.iord, bus.irwrite, bus.regwrite,
             bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.aluop,
             bus.pcsrc, bus.pcen, bus.illegal, bus.state};
      testsRun++;
      if (act !== ent.v) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %b required %b (fields rd wr iord ir rw rdst m2r a b op pcs pcen ill st)",
                  ent.tag, act, ent.v);
      end
   endtask

   // Monitor: the controller presents a new control vector every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (expQ.size() > 0)
            checkOutput(expQ.pop_front());
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [5:0] opList [6];
      logic [5:0] o;
      int pick;
      opList[0] = OP_RTYPE;
      opList[1] = OP_LB;
      opList[2] = OP_SB;
      opList[3] = OP_BEQ;
      opList[4] = OP_ADDI;
      opList[5] = OP_J;

      reset         = 1'b1;
      bus.op        = '0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      stepCycle(1, OP_SB, 1'b1, 1'b1, 4'd0, "reset_state");

      // Directed cases.
      applyStimulus(OP_RTYPE, 1'b0, 0, 0, "rtype");
      applyStimulus(OP_LB,    1'b0, 0, 3, "lb_stall3");
      applyStimulus(OP_BEQ,   1'b1, 0, 0, "beq_taken");
      applyStimulus(OP_BEQ,   1'b0, 0, 0, "beq_not_taken");
      applyStimulus(OP_SB,    1'b0, 2, 2, "sb_fetch_stall2");
      applyStimulus(6'b111111, 1'b0, 0, 0, "illegal_ff");
      applyStimulus(OP_J,     1'b0, 0, 0, "jump");
      applyStimulus(OP_ADDI,  1'b0, 1, 0, "addi");

      // Reset mid-MEMWR: two reset cycles, then a clean fetch.
      stepCycle(0, 6'h15, 1'b0, 1'b1, 4'd0, "rst_mid");
      stepCycle(0, OP_SB, 1'b0, 1'b0, 4'd1, "rst_mid");
      stepCycle(0, OP_SB, 1'b0, 1'b0, 4'd2, "rst_mid");
      stepCycle(0, OP_SB, 1'b0, 1'b0, 4'd5, "rst_mid");
      stepCycle(1, OP_SB, 1'b1, 1'b1, 4'd5, "rst_mid_r1");
      stepCycle(1, OP_SB, 1'b1, 1'b1, 4'd0, "rst_mid_r2");
      applyStimulus(OP_ADDI, 1'b0, 0, 0, "after_reset");

      // Randomized instruction stream.
      for (int n = 0; n < 300; n++) begin
         pick = $urandom_range(0, 6);
         if (pick == 6)
            o = 6'($urandom);
         else
            o = opList[pick];
         applyStimulus(o, 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                       ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                       $sformatf("rand%0d_op%b", n, o));
      end

      @(negedge clk);
      #1;
      if (expQ.size() != 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL drain: %0d entries left, required 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
